pp_buffer_axi_wr_master: RTL

AXI4 write-channel master that moves data from a local BRAM out to the DDR4 controller's AXI slave. It is the write-direction counterpart of the ping-pong buffer's DDR-to-BRAM read path. A request gives a start DDR address, a burst length, a burst count and a start BRAM address. The block reads BRAM words and issues back-to-back INCR bursts on AW/W, collecting each B response.

---
 rtl/pp_buffer_axi_wr_master.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pp_buffer_axi_wr_master.sv
// AXI4 write master: streams BRAM words to DDR as back-to-back INCR bursts,
// one burst outstanding at a time, fed by a 2-entry BRAM prefetch skid buffer.
module pp_buffer_axi_wr_master #(
    parameter int BURST_LEN_WIDTH = 8,
    parameter int NUM_BURST_WIDTH = 8,
    parameter int DDR_ADDR_WIDTH  = 29,
    parameter int DDR_DW          = 64,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int AXI_ID_WIDTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_start,
    input  logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
    input  logic [NUM_BURST_WIDTH-1:0] wr_num_burst,
    input  logic [DDR_ADDR_WIDTH-1:0]  wr_start_addr,
    input  logic [BRAM_ADDR_WIDTH-1:0] wr_start_bram_addr,
    output logic                       wr_ready,
    output logic                       wr_done,
    output logic                       wr_err,
    output logic                       bram_r_en,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_r_addr,
    input  logic [DDR_DW-1:0]          bram_rdata,
    output logic [AXI_ID_WIDTH-1:0]    m_axi_awid,
    output logic [DDR_ADDR_WIDTH-1:0]  m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awlock,
    output logic [3:0]                 m_axi_awcache,
    output logic [2:0]                 m_axi_awprot,
    output logic [3:0]                 m_axi_awqos,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [DDR_DW-1:0]          m_axi_wdata,
    output logic [DDR_DW/8-1:0]        m_axi_wstrb,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]    m_axi_bid,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic [2:0]                 dbg_state_o
);

    localparam int STRB_W = DDR_DW / 8;
    localparam int SIZE   = $clog2(STRB_W);
    localparam int FL_W   = BURST_LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                      state_q;
    logic [BURST_LEN_WIDTH-1:0]  len_q;
    logic [NUM_BURST_WIDTH-1:0]  bursts_left_q;
    logic [DDR_ADDR_WIDTH-1:0]   awaddr_q;
    logic [BRAM_ADDR_WIDTH-1:0]  bram_addr_q;
    logic [FL_W-1:0]             fetch_left_q;
    logic [BURST_LEN_WIDTH-1:0]  beat_cnt_q;
    logic                        err_q;

    logic [DDR_DW-1:0]           buf_q [2];
    logic                        wr_ptr_q;
    logic                        rd_ptr_q;
    logic [1:0]                  count_q;
    logic                        rd_valid_q;

    logic                        w_pop;
    logic                        fetch_ok;
    logic [2:0]                  credits;
    logic                        r_en;
    logic [FL_W-1:0]             len_plus1;
    logic [DDR_ADDR_WIDTH-1:0]   burst_bytes;
    logic                        unused_bid;

    // Every channel transfers on the cycle where valid and ready are both high;
    // a raised valid and its payload stay put until that cycle.
    assign w_pop    = (state_q == S_W) && (count_q != 2'd0) && m_axi_wready;
    assign fetch_ok = ((state_q == S_AW) || (state_q == S_W)) && (fetch_left_q != '0);
    // Slots held by buffered beats and the read returning this cycle, net of the beat leaving now.
    assign credits  = {1'b0, count_q} + {2'b00, rd_valid_q} - {2'b00, w_pop};
    assign r_en     = fetch_ok && (credits < 3'd2);

    assign len_plus1   = {1'b0, len_q} + FL_W'(1);
    assign burst_bytes = DDR_ADDR_WIDTH'(len_plus1) << SIZE;
    assign unused_bid  = ^m_axi_bid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            bursts_left_q <= '0;
            awaddr_q      <= '0;
            bram_addr_q   <= '0;
            fetch_left_q  <= '0;
            beat_cnt_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            if (r_en) begin
                bram_addr_q  <= bram_addr_q + BRAM_ADDR_WIDTH'(1);
                fetch_left_q <= fetch_left_q - FL_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (wr_start) begin
                        len_q         <= wr_burst_len;
                        bursts_left_q <= wr_num_burst;
                        awaddr_q      <= wr_start_addr;
                        bram_addr_q   <= wr_start_bram_addr;
                        fetch_left_q  <= {1'b0, wr_burst_len} + FL_W'(1);
                        beat_cnt_q    <= '0;
                        err_q         <= 1'b0;
                        state_q       <= (wr_num_burst == '0) ? S_DONE : S_AW;
                    end
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        awaddr_q <= awaddr_q + burst_bytes;
                        state_q  <= S_W;
                    end
                end
                S_W: begin
                    if (w_pop) begin
                        beat_cnt_q <= beat_cnt_q + BURST_LEN_WIDTH'(1);
                        if (beat_cnt_q == len_q) begin
                            state_q <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        bursts_left_q <= bursts_left_q - NUM_BURST_WIDTH'(1);
                        fetch_left_q  <= len_plus1;
                        beat_cnt_q    <= '0;
                        state_q       <= (bursts_left_q == NUM_BURST_WIDTH'(1)) ? S_DONE : S_AW;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Skid buffer: BRAM data lands one cycle after the read enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            rd_valid_q <= r_en;
            if (rd_valid_q) begin
                buf_q[wr_ptr_q] <= bram_rdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, rd_valid_q} - {1'b0, w_pop};
        end
    end

    assign wr_ready      = (state_q == S_IDLE);
    assign wr_done       = (state_q == S_DONE);
    assign wr_err        = err_q;
    assign bram_r_en     = r_en;
    assign bram_r_addr   = bram_addr_q;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'(len_q);
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = (state_q == S_AW);

    assign m_axi_wvalid  = (state_q == S_W) && (count_q != 2'd0);
    assign m_axi_wdata   = buf_q[rd_ptr_q];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = m_axi_wvalid && (beat_cnt_q == len_q);

    assign m_axi_bready  = (state_q == S_B);
    assign dbg_state_o   = state_q;

endmodule
